mulacc_dot_pipe: RTL and testbench

Parametrised, pipelined multi-lane multiply-accumulate engine. It is the next generation of the two-operand MAC used by the memory-processing datapath.
- Each accepted beat carries LANES operand pairs. The block forms their dot product and accumulates it into a wide register.
- Signed and unsigned arithmetic are both supported, with optional saturation and an overflow flag.
- Frame delimiting via `last` replaces the old manual clear/next protocol.

---
 rtl/mulacc_pkg.sv | 46 ++++
 rtl/mulacc_lane_mul.sv | 36 +++
 rtl/mulacc_dot_pipe.sv | 127 ++++++++++++
 tb/tb_mulacc_dot_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mulacc_pkg.sv
// Shared constants, stage metadata and arithmetic helpers for the dot-product MAC.
// Helpers are width-agnostic so any accumulator width up to MAX_ACC_W can reuse them.
package mulacc_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_LANES = 2;
    localparam int DEF_ACC_W = 72;
    localparam int MAX_ACC_W = 256;

    typedef struct packed {
        logic valid;
        logic last;
        logic first;
        logic mode;
    } beat_meta_t;

    // Smallest power of two that holds n leaves of the adder tree.
    function automatic int tree_leaves(input int n);
        int p;
        p = 1;
        while (p < n) begin
            p = p * 2;
        end
        return p;
    endfunction

    function automatic logic ovf_detect(input logic top_bit, input logic next_bit,
                                        input logic is_signed);
        return is_signed ? (top_bit ^ next_bit) : top_bit;
    endfunction

    // Clamp value for a width-bit accumulator; callers truncate to their width.
    function automatic logic [MAX_ACC_W-1:0] sat_value(input int width, input logic is_signed,
                                                       input logic negative);
        logic [MAX_ACC_W-1:0] ones;
        ones = {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - width);
        if (!is_signed) begin
            return ones;
        end else if (negative) begin
            return ones ^ (ones >> 1);
        end else begin
            return ones >> 1;
        end
    endfunction

endpackage

// File: rtl/mulacc_lane_mul.sv
// One lane multiplier: operands registered on capture, product registered one edge later.
// Sign-extending both operands lets a single unsigned multiply serve both modes.
module mulacc_lane_mul #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    input  logic            signed_i,
    output logic [2*DW-1:0] p_o
);

    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic            signed_q;
    logic [2*DW-1:0] a_ext;
    logic [2*DW-1:0] b_ext;
    logic [2*DW-1:0] p_d;
    logic [2*DW-1:0] p_q;

    always_comb begin
        a_ext = {{DW{signed_q & a_q[DW-1]}}, a_q};
        b_ext = {{DW{signed_q & b_q[DW-1]}}, b_q};
        p_d   = a_ext * b_ext;
    end

    always_ff @(posedge clk) begin
        a_q      <= a_i;
        b_q      <= b_i;
        signed_q <= signed_i;
        p_q      <= p_d;
    end

    assign p_o = p_q;

endmodule

// File: rtl/mulacc_dot_pipe.sv
// Pipelined multi-lane dot-product accumulator with frame delimiting by last,
// signed/unsigned arithmetic, optional saturation and a sticky overflow flag.
module mulacc_dot_pipe
    import mulacc_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int LANES    = DEF_LANES,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                last,
    input  logic                signed_mode,
    input  logic [LANES*DW-1:0] a,
    input  logic [LANES*DW-1:0] b,
    output logic [ACC_W-1:0]    psum,
    output logic                psum_valid,
    output logic                ovf,
    output logic                busy
);

    localparam int PW     = 2 * DW;
    localparam int SW     = ACC_W + 1;
    localparam int TREE_N = tree_leaves(LANES);

    logic             accept;
    logic             beat_mode;
    logic             frame_start_q;
    logic             frame_mode_q;
    beat_meta_t       cap_q;
    beat_meta_t       s1_q;
    logic [ACC_W-1:0] psum_q;
    logic [ACC_W-1:0] psum_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             psum_valid_q;

    logic [PW-1:0]    prod     [LANES];
    logic [SW-1:0]    prod_ext [LANES];
    logic [SW-1:0]    node     [1:2*TREE_N-1];
    logic [SW-1:0]    tree_sum;
    logic [SW-1:0]    acc_base;
    logic [SW-1:0]    acc_sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] psum_sat;

    assign in_ready  = reset_n & ~clear;
    assign accept    = in_valid & in_ready;
    // The frame's mode is taken from its first beat; later beats reuse the latched copy.
    assign beat_mode = frame_start_q ? signed_mode : frame_mode_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            mulacc_lane_mul #(
                .DW(DW)
            ) u_mul (
                .clk      (clk),
                .a_i      (a[gi*DW +: DW]),
                .b_i      (b[gi*DW +: DW]),
                .signed_i (beat_mode),
                .p_o      (prod[gi])
            );
            assign prod_ext[gi] = {{(SW-PW){s1_q.mode & prod[gi][PW-1]}}, prod[gi]};
        end
    endgenerate

    // Heap-ordered binary tree: leaves at TREE_N.., root at node[1].
    always_comb begin
        node = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            node[TREE_N + i] = prod_ext[i];
        end
        for (int j = TREE_N - 1; j >= 1; j--) begin
            node[j] = node[2*j] + node[2*j + 1];
        end
        tree_sum = node[1];
    end

    always_comb begin
        acc_base = s1_q.first ? '0 : {s1_q.mode & psum_q[ACC_W-1], psum_q};
        acc_sum  = acc_base + tree_sum;
        sum_ovf  = ovf_detect(acc_sum[SW-1], acc_sum[SW-2], s1_q.mode);
        psum_sat = ACC_W'(sat_value(ACC_W, s1_q.mode, acc_sum[SW-1]));
        psum_d   = ((SATURATE != 0) && sum_ovf) ? psum_sat : acc_sum[ACC_W-1:0];
        ovf_d    = sum_ovf | (ovf_q & ~s1_q.first);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            frame_start_q <= 1'b1;
            frame_mode_q  <= 1'b0;
            cap_q         <= '0;
            s1_q          <= '0;
            psum_q        <= '0;
            ovf_q         <= 1'b0;
            psum_valid_q  <= 1'b0;
        end else begin
            cap_q.valid <= accept;
            cap_q.last  <= last;
            cap_q.first <= frame_start_q;
            cap_q.mode  <= beat_mode;
            if (accept) begin
                if (frame_start_q) begin
                    frame_mode_q <= signed_mode;
                end
                frame_start_q <= last;
            end
            s1_q         <= cap_q;
            psum_valid_q <= s1_q.valid & s1_q.last;
            if (s1_q.valid) begin
                psum_q <= psum_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign psum       = psum_q;
    assign psum_valid = psum_valid_q;
    assign ovf        = ovf_q;
    assign busy       = cap_q.valid | s1_q.valid;

endmodule

// File: tb/tb_mulacc_dot_pipe.sv
// Scoreboard bench: three instances (default wide, narrow wrap, narrow saturate) share stimulus;
// expected sums come from an arbitrary-precision arithmetic model of the frame rules.
module tb_mulacc_dot_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        last = 1'b0;
    logic        signed_mode = 1'b0;
    logic [63:0] a_w = '0;
    logic [63:0] b_w = '0;
    logic [15:0] a_n = '0;
    logic [15:0] b_n = '0;

    logic [71:0] psum0;
    logic [16:0] psum1, psum2;
    logic        rdy0, rdy1, rdy2;
    logic        pv0, pv1, pv2;
    logic        ovf0, ovf1, ovf2;
    logic        busy0, busy1, busy2;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          due;
        logic [71:0] p0;
        logic [16:0] p1;
        logic [16:0] p2;
        logic [2:0]  ovf;
        logic        last;
        logic        chk_busy;
    } exp_t;

    exp_t sb[$];

    logic signed [127:0] m_acc [3];
    bit                  m_ovf [3];
    bit                  m_first [3];
    bit                  m_mode [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mulacc_dot_pipe #(.DW(32), .LANES(2), .ACC_W(72), .SATURATE(0)) u_wide (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
        .last(last), .signed_mode(signed_mode), .a(a_w), .b(b_w),
        .psum(psum0), .psum_valid(pv0), .ovf(ovf0), .busy(busy0));

    mulacc_dot_pipe #(.DW(8), .LANES(2), .ACC_W(17), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
        .last(last), .signed_mode(signed_mode), .a(a_n), .b(b_n),
        .psum(psum1), .psum_valid(pv1), .ovf(ovf1), .busy(busy1));

    mulacc_dot_pipe #(.DW(8), .LANES(2), .ACC_W(17), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
        .last(last), .signed_mode(signed_mode), .a(a_n), .b(b_n),
        .psum(psum2), .psum_valid(pv2), .ovf(ovf2), .busy(busy2));

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    function automatic logic signed [127:0] lane_val(input logic [31:0] x, input int dw,
                                                     input bit sgn);
        logic signed [127:0] m;
        logic signed [127:0] v;
        m = 128'sd1 <<< dw;
        v = $signed({96'd0, x}) & (m - 128'sd1);
        if (sgn && v >= (m >>> 1)) v = v - m;
        return v;
    endfunction

    // Mathematical sum, then range check / wrap / clamp for the instance's accumulator width.
    task automatic model_step(input int k, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input bit lst, input bit md);
        int w;
        int dw;
        logic signed [127:0] sum, lo, hi, mw;
        w  = (k == 0) ? 72 : 17;
        dw = (k == 0) ? 32 : 8;
        if (m_first[k]) begin
            m_acc[k]  = '0;
            m_ovf[k]  = 1'b0;
            m_mode[k] = md;
        end
        sum = m_acc[k] + lane_val(a0, dw, m_mode[k]) * lane_val(b0, dw, m_mode[k])
                       + lane_val(a1, dw, m_mode[k]) * lane_val(b1, dw, m_mode[k]);
        mw = 128'sd1 <<< w;
        if (m_mode[k]) begin
            lo = -(mw >>> 1);
            hi = (mw >>> 1) - 128'sd1;
        end else begin
            lo = '0;
            hi = mw - 128'sd1;
        end
        if (sum < lo || sum > hi) begin
            m_ovf[k] = 1'b1;
            if (k == 2) begin
                sum = (sum > hi) ? hi : lo;
            end else begin
                sum = sum & (mw - 128'sd1);
                if (m_mode[k] && sum > hi) sum = sum - mw;
            end
        end
        m_acc[k]   = sum;
        m_first[k] = lst;
    endtask

    task automatic flush_from(input int from);
        while (sb.size() > 0 && sb[$].due >= from) void'(sb.pop_back());
        for (int k = 0; k < 3; k++) m_first[k] = 1'b1;
    endtask

    task automatic push_zero(input int due);
        exp_t e;
        e.due = due; e.p0 = '0; e.p1 = '0; e.p2 = '0; e.ovf = '0; e.last = 1'b0; e.chk_busy = 1'b1;
        sb.push_back(e);
    endtask

    task automatic beat(input bit v, input bit lst, input bit md, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [31:0] b0, input logic [31:0] b1,
                        input bit clr);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid = v; last = lst; signed_mode = md; clear = clr;
        a_w = {a1, a0}; b_w = {b1, b0};
        a_n = {a1[7:0], a0[7:0]}; b_n = {b1[7:0], b0[7:0]};
        if (clr) begin
            flush_from(cyc + 1);
            push_zero(cyc + 1);
            #1;
            chk("clear_in_ready", {rdy2, rdy1, rdy0}, 3'b000);
        end else if (v) begin
            for (int k = 0; k < 3; k++) model_step(k, a0, a1, b0, b1, lst, md);
            e.due = cyc + 3;
            e.p0 = m_acc[0][71:0];
            e.p1 = m_acc[1][16:0];
            e.p2 = m_acc[2][16:0];
            e.ovf = {m_ovf[2], m_ovf[1], m_ovf[0]};
            e.last = lst;
            e.chk_busy = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        reset_n = 1'b0; in_valid = 1'b1; clear = 1'b0;
        flush_from(cyc + 1);
        push_zero(cyc + 1);
        #1;
        chk("reset_in_ready", {rdy2, rdy1, rdy0}, 3'b000);
        repeat (n) @(posedge clk);
        #2;
        reset_n = 1'b1; in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 15));
            2: case ($urandom_range(0, 5))
                   0: return 32'hFFFF_FFFF;
                   1: return 32'h8000_0000;
                   2: return 32'h7FFF_FFFF;
                   3: return 32'h0000_00FF;
                   4: return 32'h0000_0080;
                   default: return 32'h0000_007F;
               endcase
            default: return 32'(-int'($urandom_range(1, 16)));
        endcase
    endfunction

    // Monitor: compares every due scoreboard entry; flags psum_valid with nothing due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("missed_entry", 72'(e.due), 72'(cyc));
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                $display("txn cyc=%0d psum=%0h/%0h/%0h ovf=%b last=%b",
                         cyc, psum0, psum1, psum2, {ovf2, ovf1, ovf0}, {pv2, pv1, pv0});
                chk("psum_wide", psum0, e.p0);
                chk("psum_wrap", 72'(psum1), 72'(e.p1));
                chk("psum_sat", 72'(psum2), 72'(e.p2));
                chk("ovf", 72'({ovf2, ovf1, ovf0}), 72'(e.ovf));
                chk("psum_valid", 72'({pv2, pv1, pv0}), e.last ? 72'd7 : 72'd0);
                if (e.chk_busy) chk("busy_idle", 72'({busy2, busy1, busy0}), 72'd0);
            end else begin
                checks++;
                if (pv0 === 1'b1 || pv1 === 1'b1 || pv2 === 1'b1) begin
                    failures++;
                    $display("FAIL spurious_psum_valid cyc=%0d got=%b want=000",
                             cyc, {pv2, pv1, pv0});
                end
            end
        end
    end

    initial begin
        logic [71:0] neg7;
        neg7 = -72'sd7;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = '0; m_ovf[k] = 1'b0; m_first[k] = 1'b1; m_mode[k] = 1'b0;
        end
        do_reset(3);

        // Single unsigned beat: 3*5 + 7*11 = 92
        beat(1, 1, 0, 3, 7, 5, 11, 0);
        idle(3);
        chk("t1_psum", psum0, 72'd92);
        chk("t1_ovf", 72'(ovf0), 72'd0);

        // Back-to-back frame (11, then 94) followed by a fresh frame (2)
        beat(1, 0, 0, 1, 2, 3, 4, 0);
        beat(1, 1, 0, 5, 6, 7, 8, 0);
        beat(1, 1, 0, 1, 1, 1, 1, 0);
        idle(3);
        chk("t2_psum", psum0, 72'd2);

        // Signed: -3*5 + 2*4 = -7; then mode toggle mid-frame ignored
        beat(1, 1, 1, 32'(-3), 2, 5, 4, 0);
        idle(3);
        chk("t3_psum", psum0, neg7);
        beat(1, 0, 1, 32'(-1), 1, 1, 1, 0);
        beat(1, 1, 0, 0, 32'(-2), 0, 3, 0);
        idle(3);
        chk("t3_toggle", psum0, -72'sd6);

        // Narrow overflow: 2 beats of 255*255*2
        beat(1, 0, 0, 255, 255, 255, 255, 0);
        beat(1, 1, 0, 255, 255, 255, 255, 0);
        idle(3);
        chk("t4_wrap", 72'(psum1), 72'd129028);
        chk("t4_sat", 72'(psum2), 72'd131071);
        chk("t4_ovf", 72'({ovf2, ovf1}), 72'd3);
        beat(1, 1, 0, 1, 0, 1, 0, 0);
        idle(3);
        chk("t4_ovf_cleared", 72'({ovf2, ovf1}), 72'd0);

        // Clear while a beat is in flight, with in_valid high
        beat(1, 0, 0, 3, 3, 3, 3, 0);
        beat(1, 1, 0, 9, 9, 9, 9, 1);
        beat(1, 1, 0, 1, 0, 1, 0, 0);
        idle(3);
        chk("t5_psum", psum0, 72'd1);

        // Reset with beats in flight, then repeat the first frame
        beat(1, 0, 0, 4, 4, 4, 4, 0);
        beat(1, 0, 0, 5, 5, 5, 5, 0);
        do_reset(1);
        beat(1, 1, 0, 3, 7, 5, 11, 0);
        idle(3);
        chk("t6_psum", psum0, 72'd92);

        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                beat(1, 0, 0, rnd_op(), rnd_op(), rnd_op(), rnd_op(), 1);
            end else if (r < 4) begin
                do_reset(1);
            end else if (r < 20) begin
                idle(1);
            end else begin
                beat(1, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                     rnd_op(), rnd_op(), rnd_op(), rnd_op(), 0);
            end
        end
        idle(5);
        chk("drained", 72'(sb.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
